// File: rtl/write_arbiter_pkg.sv
// Shared constants and helpers for the write arbiter slice.
package write_arbiter_pkg;

    localparam int CNT_WIDTH = 16;

    // Width of the rotating priority pointer for a given agent count.
    function automatic int rr_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/write_arbiter_prio_select.sv
// Combinational grant selection: among agents writing the same address,
// only the one closest to rr_ptr (rotating order) is granted; agents on
// distinct addresses never block each other.
module prio_select
    import write_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NB_WRAGENT = 2,
    parameter int PTR_WIDTH  = 1
) (
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    input  logic [PTR_WIDTH-1:0]             rr_ptr,
    output logic [NB_WRAGENT-1:0]            grant,
    output logic                             collision
);

    // Distance of agent k behind the pointer; smaller means higher priority.
    function automatic int rank(input int k, input int rr);
        return (k + NB_WRAGENT - rr) % NB_WRAGENT;
    endfunction

    // Pairwise address compare; a higher-ranked colliding agent vetoes the grant.
    always_comb begin
        grant     = '0;
        collision = 1'b0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            grant[i] = wren[i];
            for (int j = 0; j < NB_WRAGENT; j++) begin
                if ((j != i) && wren[i] && wren[j] &&
                    (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == wraddr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    collision = 1'b1;
                    if (rank(j, int'(rr_ptr)) < rank(i, int'(rr_ptr))) begin
                        grant[i] = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/write_arbiter.sv
// Multi-agent write arbiter in front of a multi-port RAM. Same-address
// writes are serialised with rotating priority; losers stall on wrready.
// Optional collision statistics counter: define WRITE_ARBITER_STATS_EN.
module write_arbiter
    import write_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NB_WRAGENT = 2
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
    output logic [NB_WRAGENT-1:0]            wrready,
    output logic [NB_WRAGENT-1:0]            mem_wren,
    output logic [NB_WRAGENT*ADDR_WIDTH-1:0] mem_wraddr,
    output logic [NB_WRAGENT*DATA_WIDTH-1:0] mem_wrdata
`ifdef WRITE_ARBITER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]             collision_cnt
`endif
);

    localparam int PW = rr_width(NB_WRAGENT);

    logic [PW-1:0]         rr_ptr;
    logic [NB_WRAGENT-1:0] grant;
    logic                  collision;

    prio_select #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_WRAGENT (NB_WRAGENT),
        .PTR_WIDTH  (PW)
    ) u_prio_select (
        .wren      (wren),
        .wraddr    (wraddr),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .collision (collision)
    );

    // Idle agents are always ready; requesting agents are ready only when granted.
    assign wrready = ~wren | grant;

    // Register granted writes toward the RAM and rotate priority after a collision.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mem_wren   <= '0;
            mem_wraddr <= '0;
            mem_wrdata <= '0;
            rr_ptr     <= '0;
        end else begin
            mem_wren <= grant;
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (grant[i]) begin
                    mem_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] <= wraddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wrdata[i*DATA_WIDTH +: DATA_WIDTH] <= wrdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (collision) begin
                rr_ptr <= (rr_ptr == PW'(NB_WRAGENT - 1)) ? '0 : rr_ptr + PW'(1);
            end
        end
    end

`ifdef WRITE_ARBITER_STATS_EN
    // Saturating count of cycles that contained at least one collision.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            collision_cnt <= '0;
        end else if (collision && (collision_cnt != '1)) begin
            collision_cnt <= collision_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_write_arbiter.sv
// Bench for write_arbiter: a 3-agent and a 4-agent instance driven from
// directed vectors, checked every cycle against a rule-level model.
module tb_write_arbiter;

    logic clk = 1'b0;
    logic aresetn;

    logic [2:0]  wren3;
    logic [23:0] wraddr3, wrdata3;
    logic [2:0]  wrready3, mem_wren3;
    logic [23:0] mem_wraddr3, mem_wrdata3;
    logic [15:0] cnt3;

    logic [3:0]  wren4;
    logic [31:0] wraddr4, wrdata4;
    logic [3:0]  wrready4, mem_wren4;
    logic [31:0] mem_wraddr4, mem_wrdata4;
    logic [15:0] cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NB_WRAGENT(3)) dut3 (
        .aclk(clk), .aresetn(aresetn), .wren(wren3), .wraddr(wraddr3), .wrdata(wrdata3),
        .wrready(wrready3), .mem_wren(mem_wren3), .mem_wraddr(mem_wraddr3), .mem_wrdata(mem_wrdata3)
`ifdef WRITE_ARBITER_STATS_EN
        , .collision_cnt(cnt3)
`endif
    );

    write_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NB_WRAGENT(4)) dut4 (
        .aclk(clk), .aresetn(aresetn), .wren(wren4), .wraddr(wraddr4), .wrdata(wrdata4),
        .wrready(wrready4), .mem_wren(mem_wren4), .mem_wraddr(mem_wraddr4), .mem_wrdata(mem_wrdata4)
`ifdef WRITE_ARBITER_STATS_EN
        , .collision_cnt(cnt4)
`endif
    );

`ifndef WRITE_ARBITER_STATS_EN
    assign cnt3 = '0;
    assign cnt4 = '0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_rr[2];
    logic [3:0] m_wren[2];
    int         m_addr[2][4];
    int         m_data[2][4];
    int         m_cnt[2];
    bit         m_valid = 0;

    // Agent i wins unless some other requester on the same address sits
    // fewer rotating steps after the pointer than i does.
    function automatic logic [3:0] mgrant(input int nb, input logic [3:0] req, input int a[4], input int rr);
        logic [3:0] g = '0;
        for (int i = 0; i < nb; i++) begin
            bit win = req[i];
            for (int j = 0; j < nb; j++)
                if (j != i && req[j] && a[j] == a[i] && ((j - rr + nb) % nb) < ((i - rr + nb) % nb))
                    win = 0;
            g[i] = win;
        end
        return g;
    endfunction

    function automatic bit mcoll(input int nb, input logic [3:0] req, input int a[4]);
        for (int i = 0; i < nb; i++)
            for (int j = i + 1; j < nb; j++)
                if (req[i] && req[j] && a[i] == a[j]) return 1;
        return 0;
    endfunction

    function automatic void cur_in(input int d, output logic [3:0] req, output int a[4], output int dt[4]);
        req = '0;
        for (int i = 0; i < 4; i++) begin a[i] = 0; dt[i] = 0; end
        if (d == 0) begin
            req = {1'b0, wren3};
            for (int i = 0; i < 3; i++) begin a[i] = int'(wraddr3[i*8 +: 8]); dt[i] = int'(wrdata3[i*8 +: 8]); end
        end else begin
            req = wren4;
            for (int i = 0; i < 4; i++) begin a[i] = int'(wraddr4[i*8 +: 8]); dt[i] = int'(wrdata4[i*8 +: 8]); end
        end
    endfunction

    logic [3:0] p_req, p_g;
    int         p_a[4], p_d[4];

    // Model state advances on each rising edge from the inputs then present.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int nb;
            nb = (d == 0) ? 3 : 4;
            cur_in(d, p_req, p_a, p_d);
            if (!aresetn) begin
                m_rr[d] = 0; m_wren[d] = '0; m_cnt[d] = 0;
                for (int i = 0; i < 4; i++) begin m_addr[d][i] = 0; m_data[d][i] = 0; end
            end else begin
                p_g = mgrant(nb, p_req, p_a, m_rr[d]);
                for (int i = 0; i < nb; i++)
                    if (p_g[i]) begin m_addr[d][i] = p_a[i]; m_data[d][i] = p_d[i]; end
                m_wren[d] = p_g;
                if (mcoll(nb, p_req, p_a)) begin
                    m_rr[d] = (m_rr[d] + 1) % nb;
                    if (m_cnt[d] < 65535) m_cnt[d] = m_cnt[d] + 1;
                end
            end
        end
        if (!aresetn) m_valid = 1;
    end

    logic [3:0] c_req, c_g, c_rdy, c_mw;
    int         c_a[4], c_d[4];
    logic [31:0] c_ma, c_md;
    logic [15:0] c_cnt;

    // Compare every falling edge once the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                int nb;
                nb = (d == 0) ? 3 : 4;
                cur_in(d, c_req, c_a, c_d);
                c_g   = mgrant(nb, c_req, c_a, m_rr[d]);
                c_rdy = (d == 0) ? {1'b0, wrready3} : wrready4;
                c_mw  = (d == 0) ? {1'b0, mem_wren3} : mem_wren4;
                c_ma  = (d == 0) ? {8'h0, mem_wraddr3} : mem_wraddr4;
                c_md  = (d == 0) ? {8'h0, mem_wrdata3} : mem_wrdata4;
                c_cnt = (d == 0) ? cnt3 : cnt4;
                chk($sformatf("wrready_nb%0d", nb), 32'(c_rdy), 32'((~c_req | c_g) & 4'((1 << nb) - 1)));
                chk($sformatf("mem_wren_nb%0d", nb), 32'(c_mw), 32'(m_wren[d]));
                for (int i = 0; i < nb; i++) begin
                    chk($sformatf("mem_wraddr_nb%0d_%0d", nb, i), 32'(c_ma[i*8 +: 8]), 32'(m_addr[d][i]));
                    chk($sformatf("mem_wrdata_nb%0d_%0d", nb, i), 32'(c_md[i*8 +: 8]), 32'(m_data[d][i]));
                end
`ifdef WRITE_ARBITER_STATS_EN
                chk($sformatf("collision_cnt_nb%0d", nb), 32'(c_cnt), 32'(m_cnt[d]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set3(input logic [2:0] w, input int a0, input int a1, input int a2,
                        input int d0, input int d1, input int d2);
        wren3   = w;
        wraddr3 = {8'(a2), 8'(a1), 8'(a0)};
        wrdata3 = {8'(d2), 8'(d1), 8'(d0)};
    endtask

    task automatic set4(input logic [3:0] w, input int a0, input int a1, input int a2, input int a3);
        wren4   = w;
        wraddr4 = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        wrdata4 = {8'(a3 + 8'h40), 8'(a2 + 8'h30), 8'(a1 + 8'h20), 8'(a0 + 8'h10)};
    endtask

    logic [2:0] xfer3;
    logic [3:0] xfer4;

    initial begin
        aresetn = 1'b0;
        set3(3'b000, 0, 0, 0, 0, 0, 0);
        set4(4'b0000, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_mem_wren3", 32'(mem_wren3), 32'h0);
        chk("reset_mem_wraddr4", mem_wraddr4, 32'h0);
        aresetn = 1'b1;

        // Distinct addresses: both granted, written next cycle.
        set3(3'b011, 5, 7, 0, 8'h11, 8'h22, 0);
        #1 chk("lit_distinct_ready", 32'(wrready3), 32'b111);
        tick();
        chk("lit_distinct_memwren", 32'(mem_wren3), 32'b011);
        chk("lit_distinct_addr1", 32'(mem_wraddr3[15:8]), 32'd7);
        chk("lit_distinct_data0", 32'(mem_wrdata3[7:0]), 32'h11);
        set3(3'b000, 5, 7, 0, 0, 0, 0);
        tick();

        // Three-way collision at rr_ptr=0, stalled agents drain in order.
        set3(3'b111, 4, 4, 4, 8'hA0, 8'hA1, 8'hA2);
        #1 chk("lit_3way_ready", 32'(wrready3), 32'b001);
        tick();
        chk("lit_3way_memwren", 32'(mem_wren3), 32'b001);
        chk("lit_model_rr1", m_rr[0], 1);
        set3(3'b110, 4, 4, 4, 8'hA0, 8'hA1, 8'hA2);
        #1 chk("lit_3way_ready_b", 32'(wrready3), 32'b011);
        tick();
        chk("lit_3way_memwren_b", 32'(mem_wren3), 32'b010);
        set3(3'b100, 4, 4, 4, 8'hA0, 8'hA1, 8'hA2);
        #1 chk("lit_3way_ready_c", 32'(wrready3), 32'b111);
        tick();
        chk("lit_3way_memwren_c", 32'(mem_wren3), 32'b100);
        chk("lit_3way_data2", 32'(mem_wrdata3[23:16]), 32'hA2);

        // rr_ptr=2: agent 2 beats agent 0, then pointer wraps to 0.
        set3(3'b101, 9, 0, 9, 8'h50, 0, 8'h52);
        #1 chk("lit_wrap_ready", 32'(wrready3), 32'b110);
        tick();
        chk("lit_wrap_memwren", 32'(mem_wren3), 32'b100);
        chk("lit_model_rr_wrap", m_rr[0], 0);
        set3(3'b011, 3, 3, 0, 8'h60, 8'h61, 0);
        #1 chk("lit_after_wrap_ready", 32'(wrready3), 32'b101);
        tick();
        set3(3'b000, 0, 0, 0, 0, 0, 0);

        // Two independent collision groups on the 4-agent instance.
        set4(4'b1111, 1, 1, 2, 2);
        #1 chk("lit_groups_ready", 32'(wrready4), 32'b0101);
        tick();
        chk("lit_groups_memwren", 32'(mem_wren4), 32'b0101);
`ifdef WRITE_ARBITER_STATS_EN
        chk("lit_groups_cnt", 32'(cnt4), 32'd1);
`endif
        set4(4'b0000, 0, 0, 0, 0);
        tick();

        // Pseudo-random traffic on a small address space; stalled agents hold.
        set3(3'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        set4(4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        for (int n = 0; n < 300; n++) begin
            #1;
            xfer3 = wren3 & wrready3;
            xfer4 = wren4 & wrready4;
            tick();
            for (int i = 0; i < 3; i++)
                if (!wren3[i] || xfer3[i]) begin
                    wren3[i] = 1'($urandom);
                    wraddr3[i*8 +: 8] = 8'($urandom_range(0, 2));
                    wrdata3[i*8 +: 8] = 8'($urandom);
                end
            for (int i = 0; i < 4; i++)
                if (!wren4[i] || xfer4[i]) begin
                    wren4[i] = 1'($urandom);
                    wraddr4[i*8 +: 8] = 8'($urandom_range(0, 2));
                    wrdata4[i*8 +: 8] = 8'($urandom);
                end
        end
        set3(3'b000, 0, 0, 0, 0, 0, 0);
        set4(4'b0000, 0, 0, 0, 0);
        tick();

        // Reset in the middle of a stall discards it and restarts at rr_ptr=0.
        set3(3'b111, 6, 6, 6, 8'h70, 8'h71, 8'h72);
        tick();
        if (m_rr[0] == 0) tick();
        aresetn = 1'b0;
        tick();
        chk("lit_midreset_memwren", 32'(mem_wren3), 32'h0);
        chk("lit_midreset_addr", 32'(mem_wraddr3), 32'h0);
        chk("lit_midreset_data", 32'(mem_wrdata3), 32'h0);
        aresetn = 1'b1;
        #1 chk("lit_midreset_ready", 32'(wrready3), 32'b001);
        tick();
        chk("lit_midreset_memwren_b", 32'(mem_wren3), 32'b001);
        set3(3'b000, 0, 0, 0, 0, 0, 0);
        tick();

`ifdef WRITE_ARBITER_STATS_EN
        // Collision every cycle long enough to saturate the counter.
        set4(4'b0011, 0, 0, 1, 2);
        repeat (70000) tick();
        chk("lit_cnt_saturated", 32'(cnt4), 32'hFFFF);
        aresetn = 1'b0;
        tick();
        chk("lit_cnt_reset", 32'(cnt4), 32'h0);
        chk("lit_cnt_reset_memwren", 32'(mem_wren4), 32'h0);
        aresetn = 1'b1;
        set4(4'b0000, 0, 0, 0, 0);
        tick();
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_arbiter.md
WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning write address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning write data width.
REQ-003 SHALL have parameter NB_WRAGENT, default 2, meaning number of write agents; legal values are 2 or more.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 aclk  in  1  clock; all state updates on its rising edge.
REQ-006 aresetn  in  1  synchronous active-low reset, sampled on rising aclk.
REQ-007 wren  in  NB_WRAGENT  per-agent write request.
REQ-008 wraddr  in  NB_WRAGENT*ADDR_WIDTH  per-agent address; agent i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 wrdata  in  NB_WRAGENT*DATA_WIDTH  per-agent data; agent i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 wrready  out  NB_WRAGENT  per-agent accept, combinational from inputs and rr_ptr.
REQ-011 mem_wren  out  NB_WRAGENT  registered write enable to RAM ports.
REQ-012 mem_wraddr  out  NB_WRAGENT*ADDR_WIDTH  registered address, same packing as wraddr.
REQ-013 mem_wrdata  out  NB_WRAGENT*DATA_WIDTH  registered data, same packing as wrdata.
REQ-014 collision_cnt  out  16  saturating collision-cycle count; present only when WRITE_ARBITER_STATS_EN is defined.

Function
REQ-015 Collision: agents i!=j collide in a cycle when wren[i], wren[j] and equal addresses.
REQ-016 Priority: rotating; agent rr_ptr highest, then rr_ptr+1 ... wrapping modulo NB_WRAGENT.
REQ-017 grant[i] = wren[i] and no colliding agent j has higher priority than i.
REQ-018 wrready[i] = !wren[i] or grant[i]; transfer occurs when wren[i] and wrready[i].
REQ-019 Non-colliding agents, including separate collision groups on distinct addresses, are all granted in the same cycle.
REQ-020 Latency: mem_wren <= grant, mem_wraddr/mem_wrdata <= granted agents' inputs, one cycle after the transfer cycle.
REQ-021 Non-granted slots of mem_wraddr/mem_wrdata hold their previous value.
REQ-022 rr_ptr increments by 1 modulo NB_WRAGENT at the end of any cycle containing at least one collision, and is otherwise unchanged.
REQ-023 Wrap-around: when rr_ptr equals NB_WRAGENT-1, it increments to 0.
REQ-024 Losing agents are stalled, not dropped; they hold wren/wraddr/wrdata stable until wrready is asserted.

Reset
REQ-025 While aresetn is low at a clock edge: mem_wren=0, mem_wraddr=0, mem_wrdata=0, rr_ptr=0, and collision_cnt=0.
REQ-026 wrready is not forced low during reset; any transfer in the reset cycle is discarded, and mem_wren is 0 in the following cycle.
REQ-027 Reset asserted mid-stall SHALL discard the stall and restart arbitration with rr_ptr=0.

Configuration
REQ-028 Macro WRITE_ARBITER_STATS_EN: when defined, collision_cnt increments by 1 per collision cycle, saturates at 16'hFFFF, and is reset to 0.
REQ-029 When WRITE_ARBITER_STATS_EN is not defined, the collision_cnt port and its counter SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 Shared package write_arbiter_pkg SHALL hold the constant CNT_WIDTH=16 and the function for the rr_ptr width, $clog2(NB_WRAGENT).
REQ-031 Sub-module prio_select (wren, addresses, rr_ptr -> grant vector) SHALL be combinational only; all registers SHALL reside in write_arbiter.

Verification
REQ-032 NB=3; wren=3'b011, addr0=5, addr1=7 -> wrready=3'b111, next cycle mem_wren=3'b011.
REQ-033 NB=3, rr_ptr=0; wren=3'b111, all addr=4 -> wrready=3'b001; rr_ptr=1 next cycle; held requests are granted to agent 1 and then to agent 2 on consecutive cycles.
REQ-034 NB=3, rr_ptr=2; wren=3'b101, addr0=addr2=9 -> agent 2 granted; rr_ptr wraps to 0.
REQ-035 NB=4; addr0=addr1=1 and addr2=addr3=2, all wren, rr_ptr=0 -> grant=4'b0101; collision_cnt +1 (stats build).
REQ-036 Collision every cycle for 70000 cycles (stats build) -> collision_cnt saturates at 16'hFFFF; reset mid-stall -> all outputs 0 and rr_ptr=0.
